trap_ctrl: RTL and testbench

//  Sequences trap entry/exit for the machine-mode CSR file. Takes ecall/mret from EX and level interrupt lines.

---
 rtl/trap_ctrl_if.sv | 53 +++++
 rtl/trap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Purpose: bundles the EX-stage request, CSR-file and fetch/PC-select signals of
//          the trap controller.
// Ports (by modport):
//   master - the surrounding pipeline: drives EX request, irq lines, CSR values and
//            pipe_empty; observes stall/flush/redirect and the CSR update pulses.
//   slave  - trap_ctrl itself: the opposite directions.
interface trap_ctrl_if;
    // EX stage request side
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ecall_req;
    logic        mret_req;
    // Interrupt lines (level)
    logic        irq_sw;
    logic        irq_timer;
    logic        irq_ext;
    // CSR file values
    logic        mstatus_mie;
    logic [31:0] mie_in;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    // Pipeline status
    logic        pipe_empty;
    // Controller outputs
    logic        stall_fetch;
    logic        do_ecall;
    logic        do_mret;
    logic        do_irq;
    logic [31:0] trap_pc;
    logic [31:0] irq_cause;
    logic [31:0] mip_out;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        drain_timeout;

    modport master (
        output ex_valid, ex_pc, ecall_req, mret_req,
        output irq_sw, irq_timer, irq_ext,
        output mstatus_mie, mie_in, mtvec_in, mepc_in, pipe_empty,
        input  stall_fetch, do_ecall, do_mret, do_irq, trap_pc, irq_cause,
        input  mip_out, flush, redirect_valid, redirect_pc, busy, drain_timeout
    );

    modport slave (
        input  ex_valid, ex_pc, ecall_req, mret_req,
        input  irq_sw, irq_timer, irq_ext,
        input  mstatus_mie, mie_in, mtvec_in, mepc_in, pipe_empty,
        output stall_fetch, do_ecall, do_mret, do_irq, trap_pc, irq_cause,
        output mip_out, flush, redirect_valid, redirect_pc, busy, drain_timeout
    );
endinterface

// File: rtl/trap_ctrl.sv
// Purpose: machine-mode trap entry/exit sequencer. Picks one event (ecall, mret or
//          an enabled interrupt) from EX, stalls fetch while the pipe drains, pulses
//          the CSR-file update for one cycle, then flushes and redirects fetch.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - trap_ctrl_if.slave: EX request, irq lines, CSR values, pipe_empty in;
//          stall/flush/redirect, CSR pulses, trap_pc/irq_cause, mip_out, busy,
//          drain_timeout out.
module trap_ctrl #(
    parameter int unsigned DRAIN_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);
    // Counter only ever holds 0..DRAIN_MAX-1
    localparam int unsigned CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

    localparam logic [31:0] CAUSE_SW  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_e;
    typedef enum logic [1:0] {K_ECALL, K_MRET, K_IRQ} kind_e;

    state_e           state_q, state_d;
    kind_e            kind_q,  kind_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      pc_q,    pc_d;
    logic [31:0]      cause_q, cause_d;
    logic [31:0]      mip_q,   mip_d;
    logic             tmo_q,   tmo_d;

    logic [31:0]      irq_en;
    logic [31:0]      tvec_base;
    logic             unused_irq_en;

    // Pending bits are a plain one-cycle register of the irq lines
    always_comb begin
        mip_d     = '0;
        mip_d[3]  = bus.irq_sw;
        mip_d[7]  = bus.irq_timer;
        mip_d[11] = bus.irq_ext;
    end

    assign irq_en        = mip_q & bus.mie_in & {32{bus.mstatus_mie}};
    assign unused_irq_en = ^{irq_en[31:12], irq_en[10:8], irq_en[6:4], irq_en[2:0]};
    assign tvec_base     = {bus.mtvec_in[31:2], 2'b00};

    // State and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_ECALL;
            cnt_q   <= '0;
            pc_q    <= '0;
            cause_q <= '0;
            mip_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            mip_q   <= mip_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        tmo_d   = tmo_q;

        bus.stall_fetch    = 1'b0;
        bus.do_ecall       = 1'b0;
        bus.do_mret        = 1'b0;
        bus.do_irq         = 1'b0;
        bus.trap_pc        = '0;
        bus.irq_cause      = '0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.busy           = (state_q != S_IDLE);
        bus.mip_out        = mip_q;
        bus.drain_timeout  = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid) begin
                    // Fixed priority: ecall > mret > ext > sw > timer
                    state_d = S_DRAIN;
                    if (bus.ecall_req) begin
                        kind_d  = K_ECALL;
                        cause_d = '0;
                    end else if (bus.mret_req) begin
                        kind_d  = K_MRET;
                        cause_d = '0;
                    end else if (irq_en[11]) begin
                        kind_d  = K_IRQ;
                        cause_d = CAUSE_EXT;
                    end else if (irq_en[3]) begin
                        kind_d  = K_IRQ;
                        cause_d = CAUSE_SW;
                    end else if (irq_en[7]) begin
                        kind_d  = K_IRQ;
                        cause_d = CAUSE_TMR;
                    end else begin
                        state_d = S_IDLE;
                    end
                    if (state_d == S_DRAIN) begin
                        pc_d  = bus.ex_pc;
                        cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                bus.stall_fetch = 1'b1;
                cnt_d           = cnt_q + CNT_W'(1);
                if (bus.pipe_empty) begin
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up waiting; commit anyway and remember it happened
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            S_COMMIT: begin
                bus.stall_fetch = 1'b1;
                bus.do_ecall    = (kind_q == K_ECALL);
                bus.do_mret     = (kind_q == K_MRET);
                bus.do_irq      = (kind_q == K_IRQ);
                bus.trap_pc     = pc_q;
                bus.irq_cause   = cause_q;
                state_d         = S_REDIRECT;
            end
            S_REDIRECT: begin
                // CSR values here already reflect the update pulsed in COMMIT
                bus.stall_fetch    = 1'b1;
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                case (kind_q)
                    K_MRET:  bus.redirect_pc = bus.mepc_in;
                    K_IRQ:   bus.redirect_pc = (bus.mtvec_in[1:0] == 2'b01)
                                             ? tvec_base + {25'b0, cause_q[4:0], 2'b00}
                                             : tvec_base;
                    default: bus.redirect_pc = tvec_base;
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, hand-written multi-cycle sequences
// and a randomized run against a timeline reference model.
module tb_trap_ctrl;
    localparam int unsigned DRAIN_MAX = 8;
    localparam int K_NONE = 0;
    localparam int K_EC   = 1;
    localparam int K_MR   = 2;
    localparam int K_IRQ  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if bus();
    trap_ctrl #(.DRAIN_MAX(DRAIN_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ecall, mret, ext, timer, sw, ms;
        logic [31:0] mie, pc, mtvec, mepc;
        int          kind;
        logic [31:0] exp_pc, exp_cause, exp_redir, exp_mip;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // {busy, stall_fetch, do_ecall, do_mret, do_irq, flush, redirect_valid}
    function automatic logic [31:0] ctl();
        return 32'({bus.busy, bus.stall_fetch, bus.do_ecall, bus.do_mret,
                    bus.do_irq, bus.flush, bus.redirect_valid});
    endfunction

    function automatic logic [31:0] ctl_exp(input logic b, input logic s, input logic e,
                                            input logic m, input logic i, input logic f,
                                            input logic r);
        return 32'({b, s, e, m, i, f, r});
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ex_valid    = 1'b0;
        bus.ex_pc       = '0;
        bus.ecall_req   = 1'b0;
        bus.mret_req    = 1'b0;
        bus.irq_sw      = 1'b0;
        bus.irq_timer   = 1'b0;
        bus.irq_ext     = 1'b0;
        bus.mstatus_mie = 1'b0;
        bus.mie_in      = '0;
        bus.mtvec_in    = '0;
        bus.mepc_in     = '0;
        bus.pipe_empty  = 1'b1;
    endtask

    // Apply one table record as a complete minimum-latency sequence
    task automatic run_vec(input int idx);
        vec_t v;
        string n;
        v = tbl[idx];
        n = $sformatf("vec%0d", idx);
        adv();
        clear_inputs();
        bus.irq_ext = v.ext; bus.irq_timer = v.timer; bus.irq_sw = v.sw;
        bus.mstatus_mie = v.ms; bus.mie_in = v.mie; bus.ex_pc = v.pc;
        bus.mtvec_in = v.mtvec; bus.mepc_in = v.mepc;
        adv();
        bus.ex_valid = 1'b1; bus.ecall_req = v.ecall; bus.mret_req = v.mret;
        #2;
        chk({n, "_mip"}, bus.mip_out, v.exp_mip);
        chk({n, "_c0"}, ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
        adv();
        bus.ex_valid = 1'b0; bus.ecall_req = 1'b0; bus.mret_req = 1'b0;
        bus.irq_ext = 1'b0; bus.irq_timer = 1'b0; bus.irq_sw = 1'b0;
        #2;
        if (v.kind == K_NONE) begin
            chk({n, "_c1"}, ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
            for (int i = 2; i <= 4; i++) begin
                adv(); #2;
                chk({n, "_idle"}, ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
            end
        end else begin
            chk({n, "_c1"}, ctl(), ctl_exp(1, 1, 0, 0, 0, 0, 0));
            adv(); #2;
            chk({n, "_c2"}, ctl(), ctl_exp(1, 1, v.kind == K_EC, v.kind == K_MR,
                                           v.kind == K_IRQ, 0, 0));
            if (v.kind != K_MR) chk({n, "_trap_pc"}, bus.trap_pc, v.exp_pc);
            if (v.kind == K_IRQ) chk({n, "_cause"}, bus.irq_cause, v.exp_cause);
            adv(); #2;
            chk({n, "_c3"}, ctl(), ctl_exp(1, 1, 0, 0, 0, 1, 1));
            chk({n, "_redir"}, bus.redirect_pc, v.exp_redir);
            adv(); #2;
            chk({n, "_c4"}, ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    // Random-run reference model: a timeline counted from acceptance
    int          m_t, m_d, m_k, m_kind;
    logic [31:0] m_pc, m_cause, m_mip, m_en, m_base, m_redir;
    logic        m_to;

    initial begin
        // ecall mret ext tmr sw ms  mie  pc  mtvec mepc kind exp_pc exp_cause exp_redir exp_mip
        tbl[0] = '{1, 0, 0, 0, 0, 0, 32'h0,   32'h100, 32'h200, 32'h0,
                   K_EC,  32'h100, 32'h0, 32'h200, 32'h0};
        tbl[1] = '{0, 1, 0, 0, 0, 0, 32'h0,   32'h180, 32'h200, 32'h104,
                   K_MR,  32'h0, 32'h0, 32'h104, 32'h0};
        tbl[2] = '{0, 0, 0, 1, 0, 1, 32'h80,  32'h300, 32'h201, 32'h0,
                   K_IRQ, 32'h300, 32'h8000_0007, 32'h21C, 32'h80};
        tbl[3] = '{0, 0, 0, 1, 0, 0, 32'h80,  32'h300, 32'h201, 32'h0,
                   K_NONE, 32'h0, 32'h0, 32'h0, 32'h80};
        tbl[4] = '{0, 0, 1, 1, 1, 1, 32'h888, 32'h340, 32'h301, 32'h0,
                   K_IRQ, 32'h340, 32'h8000_000B, 32'h32C, 32'h888};
        tbl[5] = '{0, 0, 0, 1, 1, 1, 32'h88,  32'h360, 32'h1001, 32'h0,
                   K_IRQ, 32'h360, 32'h8000_0003, 32'h100C, 32'h88};
        tbl[6] = '{1, 1, 0, 0, 0, 0, 32'h0,   32'h380, 32'h203, 32'h444,
                   K_EC,  32'h380, 32'h0, 32'h200, 32'h0};
        tbl[7] = '{0, 1, 1, 0, 0, 1, 32'h800, 32'h3A0, 32'h200, 32'h444,
                   K_MR,  32'h0, 32'h0, 32'h444, 32'h800};
        tbl[8] = '{0, 0, 1, 1, 0, 1, 32'h80,  32'h3C0, 32'h400, 32'h0,
                   K_IRQ, 32'h3C0, 32'h8000_0007, 32'h400, 32'h880};
        tbl[9] = '{0, 0, 1, 0, 0, 1, 32'h800, 32'h3E0, 32'hFFFF_FFFD, 32'h0,
                   K_IRQ, 32'h3E0, 32'h8000_000B, 32'h28, 32'h800};

        // Reset state, irq lines high must not leak into mip_out
        clear_inputs();
        bus.irq_sw = 1'b1; bus.irq_timer = 1'b1; bus.irq_ext = 1'b1;
        rst = 1'b1;
        adv(); adv(); #2;
        chk("rst_ctl", ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
        chk("rst_mip", bus.mip_out, 32'h0);
        chk("rst_tmo", 32'(bus.drain_timeout), 32'h0);
        chk("rst_trap_pc", bus.trap_pc, 32'h0);
        chk("rst_cause", bus.irq_cause, 32'h0);
        chk("rst_redir", bus.redirect_pc, 32'h0);
        clear_inputs();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // ecall and ext irq together: ecall first, held irq taken at cycle 4
        adv();
        clear_inputs();
        bus.irq_ext = 1'b1; bus.mie_in = 32'h800; bus.mstatus_mie = 1'b1;
        bus.mtvec_in = 32'h200; bus.ex_pc = 32'h500;
        adv();
        bus.ex_valid = 1'b1; bus.ecall_req = 1'b1;
        adv();
        bus.ecall_req = 1'b0; bus.ex_pc = 32'h504; #2;
        chk("prio_c1", ctl(), ctl_exp(1, 1, 0, 0, 0, 0, 0));
        adv(); #2;
        chk("prio_c2", ctl(), ctl_exp(1, 1, 1, 0, 0, 0, 0));
        chk("prio_trap_pc", bus.trap_pc, 32'h500);
        adv(); #2;
        chk("prio_c3", ctl(), ctl_exp(1, 1, 0, 0, 0, 1, 1));
        chk("prio_redir", bus.redirect_pc, 32'h200);
        adv(); #2;
        chk("prio_c4_idle", ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
        adv(); #2;
        chk("prio_c5", ctl(), ctl_exp(1, 1, 0, 0, 0, 0, 0));
        adv(); #2;
        chk("prio_c6", ctl(), ctl_exp(1, 1, 0, 0, 1, 0, 0));
        chk("prio_cause2", bus.irq_cause, 32'h8000_000B);
        chk("prio_trap_pc2", bus.trap_pc, 32'h504);
        adv();
        bus.irq_ext = 1'b0; bus.ex_valid = 1'b0; #2;
        chk("prio_c7", ctl(), ctl_exp(1, 1, 0, 0, 0, 1, 1));
        adv(); #2;
        chk("prio_c8", ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));

        // Drain timeout: pipe never empties, DRAIN lasts DRAIN_MAX cycles
        adv();
        clear_inputs();
        bus.ex_valid = 1'b1; bus.ecall_req = 1'b1; bus.pipe_empty = 1'b0;
        bus.ex_pc = 32'h600; bus.mtvec_in = 32'h200;
        for (int i = 1; i <= int'(DRAIN_MAX); i++) begin
            adv();
            bus.ex_valid = 1'b0; bus.ecall_req = 1'b0; #2;
            chk($sformatf("tmo_drain%0d", i), ctl(), ctl_exp(1, 1, 0, 0, 0, 0, 0));
            chk($sformatf("tmo_flag%0d", i), 32'(bus.drain_timeout), 32'h0);
        end
        adv(); #2;
        chk("tmo_commit", ctl(), ctl_exp(1, 1, 1, 0, 0, 0, 0));
        chk("tmo_set", 32'(bus.drain_timeout), 32'h1);
        adv(); adv();
        run_vec(0);
        chk("tmo_sticky", 32'(bus.drain_timeout), 32'h1);

        // Reset in DRAIN abandons the sequence
        adv();
        clear_inputs();
        bus.ex_valid = 1'b1; bus.ecall_req = 1'b1; bus.pipe_empty = 1'b0;
        bus.irq_sw = 1'b1;
        adv();
        bus.ex_valid = 1'b0; bus.ecall_req = 1'b0; #2;
        chk("rstd_c1", ctl(), ctl_exp(1, 1, 0, 0, 0, 0, 0));
        adv(); #1;
        rst = 1'b1; #1;
        chk("rstd_ctl", ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
        chk("rstd_tmo", 32'(bus.drain_timeout), 32'h0);
        chk("rstd_mip", bus.mip_out, 32'h0);
        adv(); #2;
        bus.irq_sw = 1'b0; bus.pipe_empty = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv(); #2;
            chk("rstd_quiet", ctl(), ctl_exp(0, 0, 0, 0, 0, 0, 0));
        end
        run_vec(0);

        // Randomized run against the timeline model
        m_t = 0; m_d = 0; m_k = 0; m_kind = K_NONE;
        m_pc = '0; m_cause = '0; m_mip = '0; m_to = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            adv();
            bus.irq_sw      = ($urandom_range(0, 3) == 0);
            bus.irq_timer   = ($urandom_range(0, 3) == 0);
            bus.irq_ext     = ($urandom_range(0, 3) == 0);
            bus.mie_in      = $urandom;
            bus.mstatus_mie = 1'($urandom_range(0, 1));
            bus.ex_valid    = 1'($urandom_range(0, 1));
            bus.ecall_req   = ($urandom_range(0, 7) == 0);
            bus.mret_req    = ($urandom_range(0, 7) == 0);
            bus.ex_pc       = $urandom;
            bus.mtvec_in    = $urandom;
            bus.mepc_in     = $urandom;
            if (m_t >= 1 && m_t <= m_d) bus.pipe_empty = (m_t - 1 >= m_k);
            else                        bus.pipe_empty = 1'($urandom_range(0, 1));
            #2;
            chk("rnd_ctl", ctl(),
                ctl_exp(m_t != 0, m_t != 0,
                        m_t != 0 && m_t == m_d + 1 && m_kind == K_EC,
                        m_t != 0 && m_t == m_d + 1 && m_kind == K_MR,
                        m_t != 0 && m_t == m_d + 1 && m_kind == K_IRQ,
                        m_t != 0 && m_t == m_d + 2,
                        m_t != 0 && m_t == m_d + 2));
            chk("rnd_mip", bus.mip_out, m_mip);
            chk("rnd_tmo", 32'(bus.drain_timeout), 32'(m_to));
            if (m_t == 0 || m_t <= m_d) begin
                chk("rnd_trap_pc0", bus.trap_pc, 32'h0);
                chk("rnd_cause0", bus.irq_cause, 32'h0);
                chk("rnd_redir0", bus.redirect_pc, 32'h0);
            end else if (m_t == m_d + 1) begin
                if (m_kind != K_MR) chk("rnd_trap_pc", bus.trap_pc, m_pc);
                if (m_kind == K_IRQ) chk("rnd_cause", bus.irq_cause, m_cause);
            end else begin
                m_base = bus.mtvec_in & 32'hFFFF_FFFC;
                if (m_kind == K_MR)
                    m_redir = bus.mepc_in;
                else if (m_kind == K_IRQ && bus.mtvec_in[1:0] == 2'b01)
                    m_redir = m_base + (m_cause & 32'h1F) * 32'd4;
                else
                    m_redir = m_base;
                chk("rnd_redir", bus.redirect_pc, m_redir);
            end
            // Advance the model across the coming edge
            if (m_t == 0) begin
                m_en = m_mip & bus.mie_in & {32{bus.mstatus_mie}};
                if (bus.ex_valid && (bus.ecall_req || bus.mret_req ||
                                     m_en[11] || m_en[3] || m_en[7])) begin
                    if (bus.ecall_req)     begin m_kind = K_EC;  m_cause = 32'h0; end
                    else if (bus.mret_req) begin m_kind = K_MR;  m_cause = 32'h0; end
                    else if (m_en[11])     begin m_kind = K_IRQ; m_cause = 32'h8000_000B; end
                    else if (m_en[3])      begin m_kind = K_IRQ; m_cause = 32'h8000_0003; end
                    else                   begin m_kind = K_IRQ; m_cause = 32'h8000_0007; end
                    m_pc = bus.ex_pc;
                    m_k  = int'($urandom_range(0, DRAIN_MAX + 2));
                    m_d  = (m_k + 1 < int'(DRAIN_MAX)) ? m_k + 1 : int'(DRAIN_MAX);
                    m_t  = 1;
                end
            end else begin
                if (m_t == m_d && m_k >= int'(DRAIN_MAX)) m_to = 1'b1;
                m_t = (m_t == m_d + 2) ? 0 : m_t + 1;
            end
            m_mip = (32'(bus.irq_ext) << 11) | (32'(bus.irq_timer) << 7) |
                    (32'(bus.irq_sw) << 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
